// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: icodes, condition ifuns, status codes, register IDs,
// condition-code bit positions and the execute-stage CC state encoding.
package y86_pkg;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;

    localparam logic [3:0] C_ALWAYS = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_FROZEN = 1'b1
    } cc_state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational jXX/cmovXX condition evaluator: (cc, ifun) -> cnd.
// Shared between the execute stage and the fetch-side predictor.
module cond_eval
    import y86_pkg::*;
(
    input  logic [2:0] cc,
    input  logic [3:0] ifun,
    output logic       cnd
);

    logic zf;
    logic lt;

    assign zf = cc[CC_ZF];
    assign lt = cc[CC_SF] ^ cc[CC_OF];

    always_comb begin
        cnd = 1'b0;
        case (ifun)
            C_ALWAYS: cnd = 1'b1;
            C_LE:     cnd = lt | zf;
            C_L:      cnd = lt;
            C_E:      cnd = zf;
            C_NE:     cnd = ~zf;
            C_GE:     cnd = ~lt;
            C_G:      cnd = ~lt & ~zf;
            default:  cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_cc_ctrl.sv
// Y86-64 execute-stage controller: E register, CC register, condition evaluation,
// exception freeze. Build option EXEC_CC_STATUS_GATE_EN adds same-cycle status gating of CC writes.
module exec_cc_ctrl #(
    parameter logic [3:0] NOP_ICODE = 4'h1,
    parameter logic [3:0] RNONE     = 4'hF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d_icode,
    input  logic [3:0] d_ifun,
    input  logic [3:0] d_dstE,
    input  logic       E_stall,
    input  logic       E_bubble,
    input  logic [2:0] alu_cc,
    input  logic [2:0] m_stat,
    input  logic [2:0] W_stat,
    output logic [3:0] E_icode,
    output logic [3:0] E_ifun,
    output logic [3:0] E_dstE,
    output logic [2:0] cc,
    output logic       e_cnd,
    output logic [3:0] e_dstE,
    output logic       e_set_cc,
    output logic       e_mispredict,
    output logic       frozen
);
    import y86_pkg::*;

    logic [3:0] ex_icode_q, ex_icode_d;
    logic [3:0] ex_ifun_q,  ex_ifun_d;
    logic [3:0] ex_dste_q,  ex_dste_d;
    logic [2:0] cc_q,       cc_d;
    cc_state_e  state_q,    state_d;
    logic       status_ok;

`ifdef EXEC_CC_STATUS_GATE_EN
    // An older faulting instruction in M or W must not let this OPq touch CC.
    assign status_ok = (m_stat == S_AOK) && (W_stat == S_AOK);
`else
    logic unused_m_stat;
    assign unused_m_stat = ^m_stat;
    assign status_ok     = 1'b1;
`endif

    cond_eval u_cond_eval (
        .cc   (cc_q),
        .ifun (ex_ifun_q),
        .cnd  (e_cnd)
    );

    assign e_set_cc     = (ex_icode_q == I_OPQ) && (state_q == ST_RUN) && status_ok;
    assign e_dstE       = ((ex_icode_q == I_RRMOVQ) && !e_cnd) ? RNONE : ex_dste_q;
    assign e_mispredict = (ex_icode_q == I_JXX) && !e_cnd;

    always_comb begin
        ex_icode_d = ex_icode_q;
        ex_ifun_d  = ex_ifun_q;
        ex_dste_d  = ex_dste_q;
        if (E_bubble) begin
            ex_icode_d = NOP_ICODE;
            ex_ifun_d  = 4'h0;
            ex_dste_d  = RNONE;
        end else if (!E_stall) begin
            ex_icode_d = d_icode;
            ex_ifun_d  = d_ifun;
            ex_dste_d  = d_dstE;
        end
    end

    always_comb begin
        cc_d    = e_set_cc ? alu_cc : cc_q;
        state_d = state_q;
        if (state_q == ST_RUN && W_stat != S_AOK) begin
            state_d = ST_FROZEN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_icode_q <= NOP_ICODE;
            ex_ifun_q  <= 4'h0;
            ex_dste_q  <= RNONE;
            cc_q       <= 3'b100;
            state_q    <= ST_RUN;
        end else begin
            ex_icode_q <= ex_icode_d;
            ex_ifun_q  <= ex_ifun_d;
            ex_dste_q  <= ex_dste_d;
            cc_q       <= cc_d;
            state_q    <= state_d;
        end
    end

    assign E_icode = ex_icode_q;
    assign E_ifun  = ex_ifun_q;
    assign E_dstE  = ex_dste_q;
    assign cc      = cc_q;
    assign frozen  = (state_q == ST_FROZEN);

endmodule
